// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter that serialises write/read transactions
// onto a single register file and returns captured read data per requester.
module regfile_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [SW-1:0] wsel0,
  input  logic [SW-1:0] wsel1,
  input  logic [SW-1:0] rselA0,
  input  logic [SW-1:0] rselA1,
  input  logic [SW-1:0] rselB0,
  input  logic [SW-1:0] rselB1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdataA0,
  output logic [DW-1:0] rdataB0,
  output logic [DW-1:0] rdataA1,
  output logic [DW-1:0] rdataB1,
  output logic          busy,
  output logic          rf_EN,
  output logic          rf_write,
  output logic          rf_read,
  output logic [SW-1:0] rf_selectW1,
  output logic [SW-1:0] rf_selectR1,
  output logic [SW-1:0] rf_selectR2,
  output logic [DW-1:0] rf_addr,
  input  logic [DW-1:0] rf_outA,
  input  logic [DW-1:0] rf_outB
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;

  state_t        state, state_d;
  logic          ptr, ptr_d, owner, owner_d, grant_c;
  logic [SW-1:0] wsel_q, wsel_d, rsela_q, rsela_d, rselb_q, rselb_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          done0_d, done1_d, busy_d, en_d, write_d, read_d;
  logic [SW-1:0] selw_d, selr1_d, selr2_d;
  logic [DW-1:0] addr_d;

  // Next state plus the registered outputs that the next state will present.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    wsel_d  = wsel_q;
    rsela_d = rsela_q;
    rselb_d = rselb_q;
    wdata_d = wdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    en_d    = 1'b0;
    write_d = 1'b0;
    read_d  = 1'b0;
    selw_d  = '0;
    selr1_d = '0;
    selr2_d = '0;
    addr_d  = '0;
    grant_c = (req0 && req1) ? ptr : req1;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = grant_c;
          ptr_d   = ~grant_c;
          if (grant_c) begin
            wsel_d  = wsel1;
            rsela_d = rselA1;
            rselb_d = rselB1;
            wdata_d = wdata1;
            state_d = we1 ? WR : RD;
          end else begin
            wsel_d  = wsel0;
            rsela_d = rselA0;
            rselb_d = rselB0;
            wdata_d = wdata0;
            state_d = we0 ? WR : RD;
          end
        end
      end
      WR:      state_d = DONE;
      RD:      state_d = CAP;
      CAP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    case (state_d)
      WR: begin
        en_d    = 1'b1;
        write_d = (wsel_d != '0);  // register 0 is read-only
        selw_d  = wsel_d;
        addr_d  = wdata_d;
      end
      RD: begin
        en_d    = 1'b1;
        read_d  = 1'b1;
        selr1_d = rsela_d;
        selr2_d = rselb_d;
      end
      CAP: begin
        en_d    = 1'b1;
        selr1_d = rsela_d;
        selr2_d = rselb_d;
      end
      DONE: begin
        done0_d = ~owner_d;
        done1_d = owner_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      wsel_q      <= '0;
      rsela_q     <= '0;
      rselb_q     <= '0;
      wdata_q     <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      busy        <= 1'b0;
      rf_EN       <= 1'b0;
      rf_write    <= 1'b0;
      rf_read     <= 1'b0;
      rf_selectW1 <= '0;
      rf_selectR1 <= '0;
      rf_selectR2 <= '0;
      rf_addr     <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      owner       <= owner_d;
      wsel_q      <= wsel_d;
      rsela_q     <= rsela_d;
      rselb_q     <= rselb_d;
      wdata_q     <= wdata_d;
      done0       <= done0_d;
      done1       <= done1_d;
      busy        <= busy_d;
      rf_EN       <= en_d;
      rf_write    <= write_d;
      rf_read     <= read_d;
      rf_selectW1 <= selw_d;
      rf_selectR1 <= selr1_d;
      rf_selectR2 <= selr2_d;
      rf_addr     <= addr_d;
    end
  end

  // Read data captured at the end of CAP, only into the owner's registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataA0 <= '0;
      rdataB0 <= '0;
      rdataA1 <= '0;
      rdataB1 <= '0;
    end else if (state == CAP) begin
      if (owner) begin
        rdataA1 <= rf_outA;
        rdataB1 <= rf_outB;
      end else begin
        rdataA0 <= rf_outA;
        rdataB0 <= rf_outB;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural register file.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [7:0]  wsel0, wsel1, rselA0, rselA1, rselB0, rselB1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1, busy, rf_EN, rf_write, rf_read;
  logic [31:0] rdataA0, rdataB0, rdataA1, rdataB1, rf_addr, rf_outA, rf_outB;
  logic [7:0]  rf_selectW1, rf_selectR1, rf_selectR2;

  typedef struct {
    int          port;
    logic        rd;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf_mem [256];
  logic [31:0] exp_rf [256];
  logic [31:0] exp_a [2];
  logic [31:0] exp_b [2];
  int          total = 0;
  int          bad   = 0;

  regfile_arbiter #(.DW(32), .SW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wsel0(wsel0), .wsel1(wsel1),
    .rselA0(rselA0), .rselA1(rselA1), .rselB0(rselB0), .rselB1(rselB1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1),
    .rdataA0(rdataA0), .rdataB0(rdataB0), .rdataA1(rdataA1), .rdataB1(rdataB1),
    .busy(busy), .rf_EN(rf_EN), .rf_write(rf_write), .rf_read(rf_read),
    .rf_selectW1(rf_selectW1), .rf_selectR1(rf_selectR1), .rf_selectR2(rf_selectR2),
    .rf_addr(rf_addr), .rf_outA(rf_outA), .rf_outB(rf_outB)
  );

  always #5 clk = ~clk;

  assign rf_outA = rf_mem[rf_selectR1];
  assign rf_outB = rf_mem[rf_selectR2];
  always @(posedge clk) if (rf_EN && rf_write) rf_mem[rf_selectW1] <= rf_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop one expectation per completion pulse and compare all captured data.
  always @(negedge clk) begin
    if (rst && (done0 || done1)) begin
      chk("dual_done", 32'(done0 && done1), 32'd0);
      chk("sb_underflow", 32'(sb.size() == 0), 32'd0);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", 32'(done1), 32'(e.port));
        if (e.rd) begin
          exp_a[e.port] = e.a;
          exp_b[e.port] = e.b;
        end
        chk("rdataA0", rdataA0, exp_a[0]);
        chk("rdataB0", rdataB0, exp_b[0]);
        chk("rdataA1", rdataA1, exp_a[1]);
        chk("rdataB1", rdataB1, exp_b[1]);
        chk("rf_idle_done", 32'({rf_EN, rf_write, rf_read}), 32'd0);
      end
    end
  end

  task automatic push(input int p, input logic we, input logic [7:0] ws,
                      input logic [7:0] ra, input logic [7:0] rb, input logic [31:0] wd);
    exp_t e;
    e.port = p;
    e.rd   = ~we;
    e.a    = exp_rf[ra];
    e.b    = exp_rf[rb];
    sb.push_back(e);
    if (we && ws != 8'd0) exp_rf[ws] = wd;
  endtask

  task automatic drive(input int p, input logic rq, input logic we, input logic [7:0] ws,
                       input logic [7:0] ra, input logic [7:0] rb, input logic [31:0] wd);
    if (p == 0) begin
      req0 = rq; we0 = we; wsel0 = ws; rselA0 = ra; rselB0 = rb; wdata0 = wd;
    end else begin
      req1 = rq; we1 = we; wsel1 = ws; rselA1 = ra; rselB1 = rb; wdata1 = wd;
    end
  endtask

  // Single transaction from an idle DUT: checks rf drive, latency and input isolation.
  task automatic run_txn(input int p, input logic we, input logic [7:0] ws,
                         input logic [7:0] ra, input logic [7:0] rb, input logic [31:0] wd);
    int lat;
    logic got;
    @(negedge clk);
    drive(p, 1'b1, we, ws, ra, rb, wd);
    push(p, we, ws, ra, rb, wd);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (i == 0) begin
        chk("busy", 32'(busy), 32'd1);
        if (we) begin
          chk("rf_write", 32'(rf_write), 32'(ws != 8'd0));
          chk("rf_selectW1", 32'(rf_selectW1), 32'(ws));
          chk("rf_addr", rf_addr, wd);
        end else begin
          chk("rf_read", 32'(rf_read), 32'd1);
          chk("rf_selectR1", 32'(rf_selectR1), 32'(ra));
          chk("rf_selectR2", 32'(rf_selectR2), 32'(rb));
        end
        drive(p, 1'b1, ~we, ~ws, ~ra, ~rb, ~wd);
      end
      if (i == 1 && !we) begin
        chk("cap_en", 32'({rf_EN, rf_read}), 32'b10);
        chk("cap_sel", 32'(rf_selectR1), 32'(ra));
      end
      if ((p == 0) ? done0 : done1) got = 1'b1;
    end
    chk("latency", 32'(lat), we ? 32'd2 : 32'd3);
    drive(p, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) begin
      rf_mem[i] = 32'd0;
      exp_rf[i] = 32'd0;
    end
    exp_a[0] = 0; exp_a[1] = 0; exp_b[0] = 0; exp_b[1] = 0;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rf", 32'({rf_EN, rf_write, rf_read}), 32'd0);
    rst = 1'b1;

    // Basic write then read on the other port.
    run_txn(0, 1'b1, 8'd1, 8'd0, 8'd0, 32'd123);
    run_txn(1, 1'b0, 8'd0, 8'd1, 8'd2, 32'd0);

    // Contention: both requesters held for four writes, pointer at port 0.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 8'd3, 8'd0, 8'd0, 32'hA5A5_0003);
    drive(1, 1'b1, 1'b1, 8'd4, 8'd0, 8'd0, 32'h5A5A_0004);
    for (int i = 0; i < 4; i++) push(i % 2, 1'b1, (i % 2 == 0) ? 8'd3 : 8'd4, 8'd0, 8'd0,
                                     (i % 2 == 0) ? 32'hA5A5_0003 : 32'h5A5A_0004);
    cnt = 0;
    for (int i = 0; i < 60 && cnt < 4; i++) begin
      @(negedge clk);
      if (done0 || done1) cnt++;
    end
    chk("rr_count", 32'(cnt), 32'd4);
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rr_idle", 32'(busy), 32'd0);

    // Register 0 is read-only; then read back through both ports.
    run_txn(0, 1'b1, 8'd0, 8'd0, 8'd0, 32'd456);
    run_txn(1, 1'b0, 8'd0, 8'd0, 8'd3, 32'd0);
    run_txn(0, 1'b0, 8'd0, 8'd4, 8'd1, 32'd0);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 8'd0, 8'd3, 8'd4, 32'd0);
    @(posedge clk);
    #2;
    chk("pre_rst_read", 32'(rf_read), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_read", 32'({rf_read, rf_EN, busy}), 32'd0);
    chk("arst_done", 32'({done0, done1}), 32'd0);
    chk("arst_rdata", rdataA0 | rdataB0 | rdataA1 | rdataB1, 32'd0);
    exp_a[0] = 0; exp_a[1] = 0; exp_b[0] = 0; exp_b[1] = 0;
    drive(0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_txn(1, 1'b0, 8'd0, 8'd3, 8'd4, 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: DW, default 32, data width of register-file write data and read outputs.
REQ-002 Parameter: SW, default 8, width of register select fields.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset is asynchronous and active-low; asserted (0) clears all state immediately.
REQ-005 req0, req1  input  1 each  requester N asks for one register-file transaction; held until doneN.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read.
REQ-007 wsel0, wsel1  input  SW each  destination register for a write.
REQ-008 rselA0, rselA1, rselB0, rselB1  input  SW each  source registers for port A / port B of a read.
REQ-009 wdata0, wdata1  input  DW each  write data.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-011 rdataA0, rdataB0, rdataA1, rdataB1  output  DW each  captured read results per requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 rf_EN, rf_write, rf_read  output  1 each  drive register-file EN, write, read.
REQ-014 rf_selectW1, rf_selectR1, rf_selectR2  output  SW each  drive register-file selects.
REQ-015 rf_addr  output  DW  drives register-file data-in port (addr).
REQ-016 rf_outA, rf_outB  input  DW each  register-file read outputs.

Function
REQ-017 FSM states: IDLE, WR, RD, CAP, DONE; one transaction in flight at a time.
REQ-018 IDLE: if any req high, grant one, latch its we/wsel/rselA/rselB/wdata into holding registers, set owner, go to WR (we=1) or RD (we=0); else stay.
REQ-019 Arbitration: round-robin; priority pointer starts at port 0; on both req high, pointer port wins; pointer flips to the other port on every grant.
REQ-020 Single request: granted regardless of pointer; pointer still flips to non-winner.
REQ-021 WR: rf_EN=1, rf_write=1, rf_selectW1/rf_addr from holding registers; next state DONE.
REQ-022 Write to register 0: WR state still entered but rf_write held 0; done still issued (write silently dropped).
REQ-023 RD: rf_EN=1, rf_read=1, rf_selectR1/rf_selectR2 from holding registers; next state CAP.
REQ-024 CAP: rf_EN=1, rf_read=0, selects held; at end of cycle rf_outA/rf_outB captured into owner's rdataA/rdataB; next state DONE.
REQ-025 DONE: rf_EN=0, doneN=1 for owner only, exactly one cycle; next state IDLE.
REQ-026 Latency: req sampled at edge k -> write done at cycle k+2, read done at cycle k+3; next grant earliest at edge after DONE.
REQ-027 rf_* outputs stable for full WR/RD/CAP cycles; input changes after grant have no effect on the transaction.
REQ-028 rdata registers of non-owner never change; owner's rdata unchanged by writes; values persist until that port's next read.
REQ-029 rf_* outputs 0 in IDLE and DONE (selects and rf_addr 0).
REQ-030 req dropped after grant: transaction still completes; done still pulses.
REQ-031 req held high through DONE: treated as new request in IDLE, subject to round-robin.

Reset
REQ-032 rst=0 at any time, including mid-transaction: state=IDLE, pointer=port 0, holding registers=0, all outputs (done*, rdata*, busy, rf_*)=0 immediately; aborted transaction produces no done.
REQ-033 First grant evaluated at first rising edge after rst returns to 1.

Verification
REQ-034 req0=1, we0=1, wsel0=1, wdata0=123 -> rf_write=1, rf_selectW1=1, rf_addr=123 one cycle; done0 two cycles after grant edge; done1 stays 0.
REQ-035 After REQ-034, req1=1, we1=0, rselA1=1, rselB1=2 -> rf_read one cycle; done1 at k+3; rdataA1=123, rdataB1=0; rdataA0/B0 unchanged.
REQ-036 req0 and req1 both held for 4 writes (wsel0=3, wsel1=4) -> grants alternate 0,1,0,1; no two done pulses in same cycle.
REQ-037 req0=1, we0=1, wsel0=0, wdata0=456 -> rf_write stays 0, done0 pulses; subsequent read of register 0 returns 0.
REQ-038 rst=0 asserted during RD -> rf_read, busy, rdata*, done* drop to 0 without clock edge; after release, pending req1 (pointer at 0, only req1 high) granted normally.
